// File: rtl/add.sv
`default_nettype none
// ============================================================================
//  Module      : add
//  Description : PC incrementer. Adds the constant INC to `in` through a
//                two-level carry-lookahead adder (4-bit groups plus a group
//                lookahead unit) and registers the sum and carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module add #(
    parameter int          WIDTH = 32,   // must be a multiple of 4
    parameter int unsigned INC   = 4     // must be below 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int NUM_GRP = WIDTH / 4;

    // The second operand is a constant, so the per-bit generate/propagate
    // terms reduce to simple AND/XOR against fixed bits after synthesis.
    localparam logic [WIDTH-1:0] C_INC_VEC = WIDTH'(INC);

    logic [WIDTH-1:0]   w_gen;      // bit generate
    logic [WIDTH-1:0]   w_prop;     // bit propagate (XOR form, reused for sum)
    logic [WIDTH-1:0]   w_carry;    // carry into each bit
    logic [WIDTH-1:0]   w_sum;
    logic [NUM_GRP-1:0] w_grp_gen;
    logic [NUM_GRP-1:0] w_grp_prop;
    logic [NUM_GRP:0]   w_grp_carry; // carry into each group; top entry is cout
    logic               w_term;

    assign w_gen  = in & C_INC_VEC;
    assign w_prop = in ^ C_INC_VEC;

    // First level: each 4-bit group produces its group generate/propagate and,
    // once its group carry-in is known, its internal bit carries in one step.
    for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic       ci;

        assign g  = w_gen[4*k +: 4];
        assign p  = w_prop[4*k +: 4];
        assign ci = w_grp_carry[k];

        assign w_grp_prop[k] = &p;
        assign w_grp_gen[k]  = g[3]
                             | (p[3] & g[2])
                             | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);

        assign w_carry[4*k]   = ci;
        assign w_carry[4*k+1] = g[0] | (p[0] & ci);
        assign w_carry[4*k+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        assign w_carry[4*k+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                              | (p[2] & p[1] & p[0] & ci);
    end

    // Second level: every group carry is a flat sum of products of the group
    // generate/propagate terms (no ripple between groups). Carry-in is zero.
    always_comb begin
        w_grp_carry = '0;
        w_term      = 1'b0;
        for (int k = 1; k <= NUM_GRP; k++) begin
            for (int j = 0; j < k; j++) begin
                w_term = w_grp_gen[j];
                for (int m = j + 1; m < k; m++) begin
                    w_term = w_term & w_grp_prop[m];
                end
                w_grp_carry[k] = w_grp_carry[k] | w_term;
            end
        end
    end

    assign w_sum = w_prop ^ w_carry;

    // Output register: clears immediately on reset, otherwise captures every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            cout <= 1'b0;
        end else begin
            out  <= w_sum;
            cout <= w_grp_carry[NUM_GRP];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add
//  Description : Self-checking bench for add. Drives a 32-bit/INC=4 instance
//                and a 16-bit/INC=1 instance side by side with a queue-based
//                scoreboard of expected {cout, out} values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add;

    logic        clk;
    logic        rst;
    logic [31:0] in32;
    logic [31:0] out32;
    logic        cout32;
    logic [15:0] in16;
    logic [15:0] out16;
    logic        cout16;

    int tests;
    int fails;

    logic [32:0] q32[$];
    logic [16:0] q16[$];

    add #(.WIDTH(32), .INC(4)) dut32 (
        .clk  (clk),
        .rst  (rst),
        .in   (in32),
        .out  (out32),
        .cout (cout32)
    );

    add #(.WIDTH(16), .INC(1)) dut16 (
        .clk  (clk),
        .rst  (rst),
        .in   (in16),
        .out  (out16),
        .cout (cout16)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_32"}, {cout32, out32}, 33'd0);
        check({tag, "_16"}, {16'd0, cout16, out16}, 33'd0);
    endtask

    // One pipeline step: drive both inputs, queue the reference sums, then
    // compare against the registered outputs just after the next rising edge.
    task automatic step(input string tag, input logic [31:0] a32, input logic [15:0] a16);
        logic [32:0] e32;
        logic [16:0] e16;
        in32 = a32;
        in16 = a16;
        q32.push_back({1'b0, a32} + 33'd4);
        q16.push_back({1'b0, a16} + 17'd1);
        @(posedge clk);
        #1;
        if (q32.size() == 0 || q16.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e32 = q32.pop_front();
            e16 = q16.pop_front();
            check({tag, "_32"}, {cout32, out32}, e32);
            check({tag, "_16"}, {16'd0, cout16, out16}, {16'd0, e16});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        in32  = 32'h1234_5678;
        in16  = 16'h5678;

        // Asynchronous reset assertion before any clock edge.
        #2 rst = 1'b0;
        #1 check_zero("reset_async");

        // Held in reset while the clock runs: no capture.
        repeat (3) begin
            @(posedge clk);
            #1 check_zero("reset_hold");
        end

        // Release between edges: outputs stay zero until the first edge.
        @(negedge clk);
        rst = 1'b1;
        #1 check_zero("reset_release");

        step("basic",     32'h0000_005C, 16'h005C);

        step("stream0",   32'h0000_0000, 16'h0000);
        step("stream1",   32'h0000_0004, 16'h0004);
        step("stream2",   32'h0000_0008, 16'h0008);
        step("stream3",   32'h0000_03FC, 16'h03FC);

        step("ripple16",  32'h0000_FFFC, 16'h0FFF);
        step("ripple31",  32'h7FFF_FFFC, 16'h7FFF);
        step("wrap_exact",32'hFFFF_FFFC, 16'hFFFF);
        step("wrap_over", 32'hFFFF_FFFF, 16'hFFFE);
        step("grp_edge",  32'h00FF_FFFB, 16'h00FF);

        // Reset asserted mid-operation clears the held result at once.
        step("pre_reset", 32'h0000_0100, 16'h0100);
        #2 rst = 1'b0;
        #1 check_zero("reset_mid");
        in32 = 32'h0000_0208;
        in16 = 16'h0208;
        @(posedge clk);
        #1 check_zero("reset_mid_hold");
        @(negedge clk);
        rst = 1'b1;
        #1 check_zero("reset_mid_release");

        step("post_reset", 32'h0000_0208, 16'h0208);

        // Randomised back-to-back stream.
        for (int i = 0; i < 10000; i++) begin
            step("random", $urandom, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
